gpio_apb_ctrl: RTL and testbench

Parametrised APB GPIO controller, successor to the fixed two-bank GPIO block. It provides NUM_PORTS banks of PORT_W pins, each with:
- output-enable and output registers, plus an atomic toggle register;
- a synchronised input register;
- per-pin edge-detect interrupts with a combined level `irq` output.

It sits on the APB peripheral bus. Pad tristate buffers live in the chip top and connect through the flat `gpio_*` vectors.

---
 rtl/gpio_apb_ctrl.sv | 108 ++++++++++
 tb/tb_gpio_apb_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_ctrl.sv
// gpio_apb_ctrl: parametrised APB GPIO controller with synchronised inputs and edge interrupts
module gpio_apb_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          apb_pclk,
    input  logic                          apb_prstn,
    input  logic                          apb_psel,
    input  logic                          apb_penable,
    input  logic                          apb_pwrite,
    input  logic [31:0]                   apb_paddr,
    input  logic [31:0]                   apb_pwdata,
    output logic [31:0]                   apb_prdata,
    input  logic [NUM_PORTS*PORT_W-1:0]   gpio_i,
    output logic [NUM_PORTS*PORT_W-1:0]   gpio_o,
    output logic [NUM_PORTS*PORT_W-1:0]   gpio_oe,
    output logic                          irq
);
    localparam int N = NUM_PORTS * PORT_W;
    typedef logic [NUM_PORTS-1:0][PORT_W-1:0] bank_t;

    bank_t oe_q, oe_d, out_q, out_d, ie_q, ie_d, edg_q, edg_d;
    bank_t both_q, both_d, is_q, is_d, prev_q, prev_d;
    bank_t in_v, rise, fall, hit;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [2:0] warm_q, warm_d;
    logic [NUM_PORTS-1:0] sa, sb;
    logic wr, rd, warm_done, sel_a, sel_b, unused;
    logic [1:0] bank, regi;
    logic [PORT_W-1:0] wd;
    logic [31:0] rdata;

    assign wr        = apb_psel & apb_penable & apb_pwrite;
    assign rd        = apb_psel & apb_penable & ~apb_pwrite;
    assign sel_a     = apb_paddr[7:6] == 2'b01 && apb_paddr[1:0] == 2'b00;
    assign sel_b     = apb_paddr[7:6] == 2'b10 && apb_paddr[1:0] == 2'b00;
    assign bank      = apb_paddr[5:4];
    assign regi      = apb_paddr[3:2];
    assign wd        = apb_pwdata[PORT_W-1:0];
    assign unused    = ^apb_paddr[31:8];
    assign warm_done = warm_q == 3'(SYNC_STAGES + 1);
    assign in_v      = sync_q[SYNC_STAGES-1];
    assign rise      = in_v & ~prev_q;
    assign fall      = ~in_v & prev_q;
    // Masked during warm-up so pins already high at reset release raise no edge
    assign hit       = warm_done ? ((both_q & (rise | fall)) | (~both_q & ((edg_q & rise) | (~edg_q & fall)))) : '0;

    always_comb begin
        oe_d   = oe_q;
        out_d  = out_q;
        ie_d   = ie_q;
        edg_d  = edg_q;
        both_d = both_q;
        is_d   = is_q;
        rdata  = '0;
        prev_d = in_v;
        warm_d = warm_done ? warm_q : warm_q + 3'd1;
        sync_d[0] = gpio_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        for (int p = 0; p < NUM_PORTS; p++) begin
            sa[p]     = sel_a && bank == 2'(p);
            sb[p]     = sel_b && bank == 2'(p);
            oe_d[p]   = (wr && sa[p] && regi == 2'd0) ? wd : oe_q[p];
            out_d[p]  = (wr && sa[p] && regi == 2'd1) ? wd :
                        (wr && sa[p] && regi == 2'd3) ? out_q[p] ^ wd : out_q[p];
            ie_d[p]   = (wr && sb[p] && regi == 2'd0) ? wd : ie_q[p];
            edg_d[p]  = (wr && sb[p] && regi == 2'd1) ? wd : edg_q[p];
            both_d[p] = (wr && sb[p] && regi == 2'd2) ? wd : both_q[p];
            is_d[p]   = (is_q[p] & ~((wr && sb[p] && regi == 2'd3) ? wd : '0)) | hit[p];
            if (rd && sa[p])
                rdata = regi == 2'd0 ? 32'(oe_q[p]) : regi == 2'd1 ? 32'(out_q[p]) :
                        regi == 2'd2 ? 32'(in_v[p]) : '0;
            if (rd && sb[p])
                rdata = regi == 2'd0 ? 32'(ie_q[p]) : regi == 2'd1 ? 32'(edg_q[p]) :
                        regi == 2'd2 ? 32'(both_q[p]) : 32'(is_q[p]);
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            oe_q   <= '0;
            out_q  <= '0;
            ie_q   <= '0;
            edg_q  <= '0;
            both_q <= '0;
            is_q   <= '0;
            prev_q <= '0;
            sync_q <= '0;
            warm_q <= '0;
        end else begin
            oe_q   <= oe_d;
            out_q  <= out_d;
            ie_q   <= ie_d;
            edg_q  <= edg_d;
            both_q <= both_d;
            is_q   <= is_d;
            prev_q <= prev_d;
            sync_q <= sync_d;
            warm_q <= warm_d;
        end
    end

    assign apb_prdata = rdata;
    assign gpio_o     = out_q;
    assign gpio_oe    = oe_q;
    assign irq        = |(is_q & ie_q);
endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// tb_gpio_apb_ctrl: directed self-checking bench for gpio_apb_ctrl (2 banks x 32 pins, 2 sync stages)
module tb_gpio_apb_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic [63:0] gpio_i = '1;
    logic [63:0] gpio_o, gpio_oe;
    logic        irq;
    int          tests = 0;
    int          fails = 0;

    gpio_apb_ctrl #(.NUM_PORTS(2), .PORT_W(32), .SYNC_STAGES(2)) dut (
        .apb_pclk(clk), .apb_prstn(rst_n), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_prdata(prdata),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Returns 1 ns after the access edge, so a write is already visible
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        psel = 1; pwrite = 0; penable = 0; paddr = a;
        @(posedge clk); #1;
        penable = 1;
        #2 d = prdata;
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic test_reset;
        logic [31:0] r, exp;
        gpio_i = '1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
        tests++; if (gpio_o !== 64'h0) begin fails++; $display("FAIL reset_gpio_o got %h want 0", gpio_o); end
        tests++; if (gpio_oe !== 64'h0) begin fails++; $display("FAIL reset_gpio_oe got %h want 0", gpio_oe); end
        for (int i = 0; i < 8; i++) begin
            apb_read(32'h40 + 4 * i, r);
            exp = (i % 4 == 2) ? 32'hFFFF_FFFF : 32'h0;
            tests++; if (r !== exp) begin fails++; $display("FAIL reset_rd_%h got %h want %h", 32'h40 + 4 * i, r, exp); end
            apb_read(32'h80 + 4 * i, r);
            tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_rd_%h got %h want 0", 32'h80 + 4 * i, r); end
        end
        // Drop all pins: falling-edge mode is the reset default, so every IS bit sets
        gpio_i = '0;
        repeat (5) @(posedge clk);
        apb_read(32'h8C, r);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL fall_is0 got %h want ffffffff", r); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL fall_irq_masked got %b want 0", irq); end
        apb_write(32'h8C, 32'hFFFF_FFFF);
        apb_write(32'h9C, 32'hFFFF_FFFF);
        apb_read(32'h9C, r);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL w1c_is1 got %h want 0", r); end
    endtask

    task automatic test_output_toggle;
        logic [31:0] r;
        apb_write(32'h40, 32'h0000_FFFF);
        apb_write(32'h44, 32'h0000_00F0);
        apb_write(32'h4C, 32'h0000_00FF);
        tests++; if (gpio_o !== 64'h0000_0000_0000_000F) begin fails++; $display("FAIL tgl_gpio_o got %h want f", gpio_o); end
        tests++; if (gpio_oe !== 64'h0000_0000_0000_FFFF) begin fails++; $display("FAIL tgl_gpio_oe got %h want ffff", gpio_oe); end
        apb_read(32'h44, r);
        tests++; if (r !== 32'h0000_000F) begin fails++; $display("FAIL tgl_out0 got %h want f", r); end
        apb_read(32'h4C, r);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL tgl_read got %h want 0", r); end
    endtask

    task automatic test_rising_irq;
        logic [31:0] r;
        apb_write(32'h90, 32'h4);
        apb_write(32'h94, 32'h4);
        @(posedge clk); #1;
        gpio_i[34] = 1;
        psel = 1; pwrite = 0; penable = 0; paddr = 32'h58;
        @(posedge clk); #1;
        penable = 1;
        tests++; if (prdata[2] !== 1'b0) begin fails++; $display("FAIL in1_early got %b want 0", prdata[2]); end
        @(posedge clk); #1;
        tests++; if (prdata[2] !== 1'b1) begin fails++; $display("FAIL in1_c2 got %b want 1", prdata[2]); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_c2 got %b want 0", irq); end
        @(posedge clk); #1;
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_c3 got %b want 1", irq); end
        psel = 0; penable = 0;
        apb_read(32'h9C, r);
        tests++; if (r !== 32'h4) begin fails++; $display("FAIL is1_rise got %h want 4", r); end
        apb_write(32'h9C, 32'h4);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_w1c got %b want 0", irq); end
    endtask

    task automatic test_both_disabled;
        logic [31:0] r;
        apb_write(32'h88, 32'h20);
        @(posedge clk); #1 gpio_i[5] = 1;
        repeat (3) @(posedge clk);
        #1 gpio_i[5] = 0;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL both_irq_off got %b want 0", irq); end
        apb_read(32'h8C, r);
        tests++; if (r !== 32'h20) begin fails++; $display("FAIL both_is0 got %h want 20", r); end
        apb_write(32'h80, 32'h20);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL ie_late_irq got %b want 1", irq); end
        apb_write(32'h80, 32'h0);
        apb_write(32'h8C, 32'h20);
        apb_write(32'h88, 32'h0);
    endtask

    task automatic test_set_wins;
        logic [31:0] r;
        @(posedge clk); #1 gpio_i[0] = 1;
        repeat (5) @(posedge clk);
        #1 gpio_i[0] = 0;
        @(posedge clk); #1;
        psel = 1; pwrite = 1; penable = 0; paddr = 32'h8C; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
        apb_read(32'h8C, r);
        tests++; if (r !== 32'h1) begin fails++; $display("FAIL set_wins got %h want 1", r); end
        apb_write(32'h8C, 32'h1);
        apb_read(32'h8C, r);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL w1c_plain got %h want 0", r); end
    endtask

    task automatic test_decode;
        logic [31:0] r;
        logic [31:0] bad [4] = '{32'h60, 32'h70, 32'hA0, 32'h3C};
        logic [31:0] chk_a [8] = '{32'h40, 32'h44, 32'h50, 32'h54, 32'h80, 32'h88, 32'h90, 32'h94};
        logic [31:0] chk_v [8] = '{32'hFFFF, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4};
        foreach (bad[i]) apb_write(bad[i], 32'hFFFF_FFFF);
        foreach (bad[i]) begin
            apb_read(bad[i], r);
            tests++; if (r !== 32'h0) begin fails++; $display("FAIL dec_rd_%h got %h want 0", bad[i], r); end
        end
        foreach (chk_a[i]) begin
            apb_read(chk_a[i], r);
            tests++; if (r !== chk_v[i]) begin fails++; $display("FAIL dec_keep_%h got %h want %h", chk_a[i], r, chk_v[i]); end
        end
        tests++; if (gpio_o !== 64'hF) begin fails++; $display("FAIL dec_gpio_o got %h want f", gpio_o); end
        @(posedge clk); #1;
        psel = 1; pwrite = 0; penable = 0; paddr = 32'h40;
        #2;
        tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL rd_setup_phase got %h want 0", prdata); end
        psel = 0;
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        @(posedge clk); #1 gpio_i[1] = 1;
        repeat (4) @(posedge clk);
        #1 gpio_i[1] = 0;
        repeat (5) @(posedge clk);
        apb_write(32'h80, 32'h2);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pre_rst_irq got %b want 1", irq); end
        @(posedge clk); #3 rst_n = 0;
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL async_rst_irq got %b want 0", irq); end
        tests++; if (gpio_oe !== 64'h0) begin fails++; $display("FAIL async_rst_oe got %h want 0", gpio_oe); end
        tests++; if (gpio_o !== 64'h0) begin fails++; $display("FAIL async_rst_o got %h want 0", gpio_o); end
        @(posedge clk); #1 rst_n = 1;
        apb_read(32'h8C, r);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL async_rst_is got %h want 0", r); end
    endtask

    initial begin
        test_reset;
        test_output_toggle;
        test_rising_irq;
        test_both_disabled;
        test_set_wins;
        test_decode;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
